// File: rtl/ocb_offset_gen.sv
// OCB offset generator: precomputes L_$ and the L_j table by GF(2^128)
// doubling, then returns one running offset per request (Offset_i or
// Offset_*) through a single output register.
module ocb_offset_gen #(
    parameter int DATA_WIDTH  = 128,
    parameter int TABLE_DEPTH = 32,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_valid,
    output logic                  init_ready,
    input  logic [DATA_WIDTH-1:0] init_l,
    input  logic [DATA_WIDTH-1:0] init_offset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_star,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_offset,
    output logic [CNT_WIDTH-1:0]  out_index,
    output logic                  out_star,
    output logic [DATA_WIDTH-1:0] l_dollar,
    output logic                  busy,
    output logic                  err_overflow
);

    localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
    localparam int PC_W  = $clog2(TABLE_DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [PC_W-1:0]      PC_END  = PC_W'(TABLE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRECOMP = 2'd1,
        S_READY   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] l_star;
    logic [DATA_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] chain;
    logic [DATA_WIDTH-1:0] l_tab [TABLE_DEPTH];
    logic [DATA_WIDTH-1:0] offset_full;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  count_inc;
    logic [PC_W-1:0]       pc;
    logic [PC_W-1:0]       pc_m1;
    logic [IDX_W-1:0]      ntz;
    logic                  init_acc;
    logic                  req_acc;
    logic                  out_fire;
    logic                  pc_last;
    logic                  at_max;

    // Multiply by x in GF(2^128); bit 127 is the first bit of the OCB string.
    function automatic logic [DATA_WIDTH-1:0] dbl(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] red;
        red = x[DATA_WIDTH-1] ? DATA_WIDTH'(8'h87) : '0;
        return {x[DATA_WIDTH-2:0], 1'b0} ^ red;
    endfunction

    assign init_acc    = init_valid && init_ready;
    assign req_acc     = req_valid && req_ready;
    assign out_fire    = out_valid && out_ready;
    assign count_inc   = count + 1'b1;
    assign at_max      = (count == CNT_MAX);
    assign pc_last     = (pc == PC_END);
    assign pc_m1       = pc - 1'b1;
    assign offset_full = offset ^ l_tab[ntz];

    // Number of trailing zeros of the next block index (lowest set bit wins).
    always_comb begin
        ntz = '0;
        for (int b = CNT_WIDTH - 1; b >= 0; b--) begin
            if (count_inc[b]) begin
                ntz = IDX_W'(b);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; init takes priority over requests in READY.
    always_comb begin
        state_next = state;
        init_ready = 1'b0;
        req_ready  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                init_ready = 1'b1;
                if (init_valid) begin
                    state_next = S_PRECOMP;
                end
            end
            S_PRECOMP: begin
                busy = 1'b1;
                if (pc_last) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                init_ready = !out_valid;
                if (init_valid && !out_valid) begin
                    state_next = S_PRECOMP;
                end else begin
                    // A pending star output or an overflow closes the stream until re-init.
                    req_ready = (!out_valid || out_ready) && !err_overflow
                                && !(out_valid && out_star);
                    if (out_valid && out_star && out_ready) begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: init latch, table precompute, running offset and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_star       <= '0;
            offset       <= '0;
            chain        <= '0;
            count        <= '0;
            pc           <= '0;
            l_dollar     <= '0;
            err_overflow <= 1'b0;
            out_valid    <= 1'b0;
            out_offset   <= '0;
            out_index    <= '0;
            out_star     <= 1'b0;
            for (int j = 0; j < TABLE_DEPTH; j++) begin
                l_tab[j] <= '0;
            end
        end else begin
            if (out_fire) begin
                out_valid <= 1'b0;
            end

            if (init_acc) begin
                l_star       <= init_l;
                offset       <= init_offset;
                count        <= '0;
                pc           <= '0;
                err_overflow <= 1'b0;
            end else if (state == S_PRECOMP) begin
                // Step 0 produces L_$, step k+1 produces L_k from the previous doubling.
                if (pc == '0) begin
                    l_dollar <= dbl(l_star);
                    chain    <= dbl(l_star);
                end else begin
                    l_tab[pc_m1[IDX_W-1:0]] <= dbl(chain);
                    chain                   <= dbl(chain);
                end
                pc <= pc + 1'b1;
            end else if (req_acc) begin
                if (req_star) begin
                    out_valid  <= 1'b1;
                    out_offset <= offset ^ l_star;
                    out_index  <= count;
                    out_star   <= 1'b1;
                end else if (at_max) begin
                    err_overflow <= 1'b1;
                end else begin
                    offset     <= offset_full;
                    count      <= count_inc;
                    out_valid  <= 1'b1;
                    out_offset <= offset_full;
                    out_index  <= count_inc;
                    out_star   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/ocb_offset_gen.md
Name: ocb_offset_gen

Overview:
- Generates the per-block OCB offsets that feed the 128-bit XOR stages around the AES core (pre-whitening P_i^Offset_i, post-whitening).
- Takes L_* = E_K(0^128) and the nonce-derived Offset_0 from the setup path.
- Precomputes L_$ and the L_j table by GF(2^128) doubling, then serves Offset_i = Offset_{i-1} ^ L_{ntz(i)}, plus Offset_* for a partial final block.

Parameters:
- DATA_WIDTH, 128, block/offset width; only 128 is supported (doubling polynomial fixed).
- TABLE_DEPTH, 32, number of L_j entries (j = 0..TABLE_DEPTH-1).
- CNT_WIDTH, 32, block index counter width; must be <= TABLE_DEPTH.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- init_valid, in, 1, init_l and init_offset are valid.
- init_ready, out, 1, block can accept init.
- init_l, in, DATA_WIDTH, L_* = E_K(0^128).
- init_offset, in, DATA_WIDTH, Offset_0.
- req_valid, in, 1, request the next offset.
- req_ready, out, 1, request accepted this cycle when valid&ready.
- req_star, in, 1, qualified by req_valid; request Offset_* (partial final block).
- out_valid, out, 1, out_offset/out_index valid.
- out_ready, in, 1, consumer takes the output.
- out_offset, out, DATA_WIDTH, Offset_i or Offset_*.
- out_index, out, CNT_WIDTH, i for full blocks; last full-block index for star.
- out_star, out, 1, out_offset is Offset_*.
- l_dollar, out, DATA_WIDTH, L_$ for tag computation; stable from READY until next init.
- busy, out, 1, high in PRECOMP.
- err_overflow, out, 1, sticky; the block counter would exceed 2^CNT_WIDTH-1.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. All outputs 0 except init_ready=1. L table, counter, and offset registers cleared.
- Doubling: dbl(X) = {X[126:0],1'b0} ^ (X[127] ? 128'h87 : 0). Bit 127 is the first bit of the OCB string.
- FSM IDLE:
  - init_ready=1.
  - On init_valid: latch L_*, Offset_0 into the running offset; count=0; go to PRECOMP.
- FSM PRECOMP: busy=1, init_ready=0, req_ready=0. One doubling per cycle.
  - Cycle 0: L_$ = dbl(L_*).
  - Cycle 1: L_0 = dbl(L_$).
  - Cycle k+1: L_k = dbl(L_{k-1}).
  - Total TABLE_DEPTH+1 cycles, then go to READY.
- FSM READY:
  - req_ready = !out_valid || out_ready (single output register, full throughput).
  - init_ready = !out_valid. Init here restarts from IDLE behaviour; the pending table is discarded.
  - Full request (req_star=0):
    - n = count+1; ntz(n) is a priority encode of the lowest set bit.
    - offset <= offset ^ L_{ntz(n)}; count <= n.
    - out_offset = new offset, out_index = n, out_star=0.
    - out_valid rises the cycle after acceptance (1-cycle latency).
  - Star request:
    - out_offset = offset ^ L_*, out_index = count, out_star=1.
    - Running offset and count are unchanged. FSM goes to IDLE once the star output is accepted; no further req_ready until a new init.
  - Overflow: a full request when count == 2^CNT_WIDTH-1 is accepted but produces no output and sets err_overflow. req_ready then stays 0 until a new init. A new init clears err_overflow.
- Output hold: out_valid, out_offset, out_index, and out_star stay stable until out_valid & out_ready. out_valid drops the cycle after the handshake unless a new request was accepted in the same cycle.
- Simultaneous init_valid and req_valid in READY: init wins; the request is not accepted (req_ready forced 0 when init_valid & init_ready).
- Reset mid-operation (any state): immediate return to reset values; any pending output is lost.
- l_dollar is valid from the cycle PRECOMP exits.

Test Plan:
- Precompute: init_l=128'h8000...0, init_offset=0 -> busy for 33 cycles; l_dollar=128'h87; internal L_0=128'h10E, L_1=128'h21C, L_2=128'h438.
- Sequence: same init, 4 full requests back-to-back with out_ready=1 -> out_offset = 0x10E, 0x312, 0x21C, 0x624; out_index 1..4; one output per cycle after a 1-cycle latency.
- Star: after 2 full requests, req_star=1 -> out_offset = 0x312 ^ 0x8000...0, out_index=2, out_star=1; FSM returns to IDLE and init_ready=1.
- Backpressure: out_ready=0 for 5 cycles with req_valid held -> req_ready=0 and the output is stable. Releasing out_ready yields the next offsets in order with none lost or duplicated.
- Overflow: CNT_WIDTH=4 build, 15 requests then a 16th -> err_overflow=1, no 16th output, req_ready=0. A new init clears it.
- Reset: assert rst_n=0 during PRECOMP and with out_valid=1 -> all outputs at reset values asynchronously; a fresh init reproduces the sequence-test results.
